// File: rtl/led_mode_sequencer.sv
// LED pattern sequencer: prescaled pattern ticks, debounced mode/hold buttons,
// four pattern modes and registered LED/status outputs.

module led_mode_debounce #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  logic             sync_p0;
  logic             sync_p1;
  logic [WIDTH-1:0] cnt;

  // Two-flop synchronizer, then a disagreement counter that flips the level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      if (sync_p1 != level) begin
        if (&cnt) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

module led_mode_sequencer #(
  parameter int TICK_WIDTH     = 24,
  parameter int DEBOUNCE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        btn_hold,
  output logic [7:0]  LED,
  output logic [23:0] IO_LED,
  output logic [1:0]  mode,
  output logic        tick
);

  localparam logic [1:0] CHASE  = 2'd0;
  localparam logic [1:0] BOUNCE = 2'd1;
  localparam logic [1:0] COUNT  = 2'd2;
  localparam logic [1:0] FILL   = 2'd3;

  logic [TICK_WIDTH-1:0] presc_p0;
  logic                  next_lvl;
  logic                  hold_lvl;
  logic                  next_lvl_q;
  logic                  press;
  logic                  apply;
  logic [1:0]            mode_nxt;
  logic [7:0]            pat_p0;
  logic                  dir_left_p0;
  logic [7:0]            tick_cnt_p0;
  logic [7:0]            chg_cnt_p0;
  logic [7:0]            pat_d;
  logic                  dir_left_d;

  // Stage 0: prescaler and input conditioning
  always_ff @(posedge clk) begin
    if (rst) presc_p0 <= '0;
    else     presc_p0 <= presc_p0 + TICK_WIDTH'(1);
  end

  assign tick = &presc_p0;

  led_mode_debounce #(.WIDTH(DEBOUNCE_WIDTH)) u_db_next (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_next),
    .level (next_lvl)
  );

  led_mode_debounce #(.WIDTH(DEBOUNCE_WIDTH)) u_db_hold (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_hold),
    .level (hold_lvl)
  );

  assign press    = next_lvl & ~next_lvl_q;
  assign apply    = tick & ~hold_lvl & ~press;
  assign mode_nxt = mode + 2'd1;

  function automatic logic [7:0] mode_init(input logic [1:0] m);
    return (m == CHASE || m == BOUNCE) ? 8'h01 : 8'h00;
  endfunction

  always_comb begin
    pat_d      = pat_p0;
    dir_left_d = dir_left_p0;
    case (mode)
      CHASE:  pat_d = {pat_p0[6:0], ~|pat_p0[6:0]};
      BOUNCE: begin
        if (dir_left_p0) begin
          if (pat_p0[7]) begin
            pat_d      = pat_p0 >> 1;
            dir_left_d = 1'b0;
          end else begin
            pat_d = pat_p0 << 1;
          end
        end else begin
          if (pat_p0[0]) begin
            pat_d      = pat_p0 << 1;
            dir_left_d = 1'b1;
          end else begin
            pat_d = pat_p0 >> 1;
          end
        end
      end
      COUNT:  pat_d = pat_p0 + 8'd1;
      FILL:   pat_d = {pat_p0[6:0], ~pat_p0[7]};
      default: ;
    endcase
  end

  // Stage 1: mode/pattern state; a press outranks a same-cycle tick
  always_ff @(posedge clk) begin
    if (rst) begin
      next_lvl_q  <= 1'b0;
      mode        <= CHASE;
      pat_p0      <= 8'h01;
      dir_left_p0 <= 1'b1;
      tick_cnt_p0 <= 8'd0;
      chg_cnt_p0  <= 8'd0;
    end else begin
      next_lvl_q <= next_lvl;
      if (press) begin
        mode        <= mode_nxt;
        pat_p0      <= mode_init(mode_nxt);
        dir_left_p0 <= 1'b1;
        tick_cnt_p0 <= 8'd0;
        chg_cnt_p0  <= chg_cnt_p0 + 8'd1;
      end else if (apply) begin
        pat_p0      <= pat_d;
        dir_left_p0 <= dir_left_d;
        tick_cnt_p0 <= tick_cnt_p0 + 8'd1;
      end
    end
  end

  // Stage 2: registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      LED    <= 8'h01;
      IO_LED <= 24'h000001;
    end else begin
      LED    <= pat_p0;
      IO_LED <= {tick_cnt_p0, chg_cnt_p0, 4'h0, 4'b0001 << mode};
    end
  end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Scoreboard bench for led_mode_sequencer: every change of LED/IO_LED is
// matched in order against expected output states pushed by the stimulus.

module tb_led_mode_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_next;
  logic        btn_hold;
  logic [7:0]  LED;
  logic [23:0] IO_LED;
  logic [1:0]  mode;
  logic        tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [7:0]  led;
    logic [23:0] io;
    logic [1:0]  md;
  } exp_t;

  exp_t exp_q[$];

  led_mode_sequencer #(.TICK_WIDTH(4), .DEBOUNCE_WIDTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_next (btn_next),
    .btn_hold (btn_hold),
    .LED      (LED),
    .IO_LED   (IO_LED),
    .mode     (mode),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic expect_out(input string tag, input logic [7:0] led,
                            input logic [7:0] tc, input logic [7:0] cc,
                            input logic [1:0] md);
    exp_t e;
    e.tag = tag;
    e.led = led;
    e.io  = {tc, cc, 4'h0, 4'b0001 << md};
    e.md  = md;
    exp_q.push_back(e);
  endtask

  // Each iteration returns just after the clock edge that consumes a tick.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      @(negedge clk);
      while (!tick && g < 64) begin
        @(negedge clk);
        g++;
      end
      if (!tick) begin
        checks++;
        errors++;
        $display("FAIL tick_timeout: no tick seen within %0d cycles, required a tick", g);
        return;
      end
      @(posedge clk);
    end
  endtask

  // The mode change lands on the 7th rising edge after btn_next goes high.
  task automatic press(input int pre);
    repeat (pre) @(posedge clk);
    @(negedge clk);
    btn_next = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    btn_next = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  // Monitor: pops one expectation per observed output change.
  initial begin
    logic [31:0] prev;
    logic [31:0] cur;
    exp_t        e;
    prev = 'x;
    forever begin
      @(negedge clk);
      cur = {LED, IO_LED};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: LED=%h IO_LED=%h mode=%0d, required no change",
                   LED, IO_LED, mode);
        end else begin
          e = exp_q.pop_front();
          if (LED !== e.led || IO_LED !== e.io || mode !== e.md) begin
            errors++;
            $display("FAIL %s: got LED=%h IO_LED=%h mode=%0d, required LED=%h IO_LED=%h mode=%0d",
                     e.tag, LED, IO_LED, mode, e.led, e.io, e.md);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  logic [7:0] bounce_tbl [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  logic [7:0] fill_tbl [16]   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                  8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

  initial begin
    rst      = 1'b1;
    btn_next = 1'b0;
    btn_hold = 1'b0;
    expect_out("reset", 8'h01, 8'd0, 8'd0, 2'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 1; i <= 8; i++)
      expect_out("chase", 8'h01 << (i % 8), 8'(i), 8'd0, 2'd0);
    wait_ticks(8);

    @(negedge clk);
    btn_next = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    btn_next = 1'b0;
    expect_out("chase_after_glitch", 8'h02, 8'd9, 8'd0, 2'd0);
    wait_ticks(1);

    expect_out("press_bounce", 8'h01, 8'd0, 8'd1, 2'd1);
    press(0);
    for (int i = 0; i < 14; i++)
      expect_out("bounce", bounce_tbl[i], 8'(i + 1), 8'd1, 2'd1);
    wait_ticks(14);

    expect_out("press_count", 8'h00, 8'd0, 8'd2, 2'd2);
    press(0);
    for (int i = 1; i <= 256; i++)
      expect_out("count", 8'(i), 8'(i), 8'd2, 2'd2);
    wait_ticks(256);

    expect_out("press_fill", 8'h00, 8'd0, 8'd3, 2'd3);
    press(0);
    for (int i = 0; i < 16; i++)
      expect_out("fill", fill_tbl[i], 8'(i + 1), 8'd3, 2'd3);
    wait_ticks(16);

    @(negedge clk);
    btn_hold = 1'b1;
    wait_ticks(5);
    checks++;
    if (exp_q.size() != 0 || LED !== 8'h00 || IO_LED[23:16] !== 8'd16) begin
      errors++;
      $display("FAIL hold_frozen: LED=%h ticks=%0d pending=%0d, required LED=00 ticks=16 pending=0",
               LED, IO_LED[23:16], exp_q.size());
    end
    expect_out("press_in_hold", 8'h01, 8'd0, 8'd4, 2'd0);
    press(0);
    wait_ticks(1);
    @(negedge clk);
    btn_hold = 1'b0;
    expect_out("chase_after_hold", 8'h02, 8'd1, 8'd4, 2'd0);
    expect_out("chase_after_hold", 8'h04, 8'd2, 8'd4, 2'd0);
    wait_ticks(2);

    expect_out("press_on_tick", 8'h01, 8'd0, 8'd5, 2'd1);
    press(9);
    expect_out("bounce_after_prio", 8'h02, 8'd1, 8'd5, 2'd1);
    wait_ticks(1);
    expect_out("press_count2", 8'h00, 8'd0, 8'd6, 2'd2);
    press(0);
    expect_out("count2", 8'h01, 8'd1, 8'd6, 2'd2);
    wait_ticks(1);
    expect_out("press_fill2", 8'h00, 8'd0, 8'd7, 2'd3);
    press(0);
    for (int i = 0; i < 3; i++)
      expect_out("fill2", fill_tbl[i], 8'(i + 1), 8'd7, 2'd3);
    wait_ticks(3);

    repeat (3) @(posedge clk);
    expect_out("reset_mid_fill", 8'h01, 8'd0, 8'd0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_tick: tick=%b, required 0", tick);
    end
    rst = 1'b0;
    expect_out("chase_after_reset", 8'h02, 8'd1, 8'd0, 2'd0);
    expect_out("chase_after_reset", 8'h04, 8'd2, 8'd0, 2'd0);
    wait_ticks(2);

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never appeared, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_mode_sequencer.md
LED_MODE_SEQUENCER -- requirements
Module: led_mode_sequencer

Interface
REQ-001 SHALL have parameter TICK_WIDTH, default 24: prescaler width; one pattern tick every 2^TICK_WIDTH clk cycles.
REQ-002 SHALL have parameter DEBOUNCE_WIDTH, default 16: a button level must be stable for 2^DEBOUNCE_WIDTH cycles before it is accepted.
REQ-003 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port btn_next  input  1  raw asynchronous pushbutton, active-high; a press advances the mode.
REQ-006 SHALL have port btn_hold  input  1  raw asynchronous switch, active-high; while its debounced level is high, the pattern freezes.
REQ-007 SHALL have port LED  output  8  registered pattern output.
REQ-008 SHALL have port IO_LED  output  24  registered status: [23:16] tick count, [15:8] mode-change count, [7:4] zero, [3:0] one-hot mode.
REQ-009 SHALL have port mode  output  2  current mode encoding.
REQ-010 SHALL have port tick  output  1  one-cycle prescaler pulse.

Function
REQ-011 SHALL implement the prescaler as a free-running TICK_WIDTH-bit up-counter; tick is high exactly in the cycle the counter equals all-ones, and the counter then wraps to 0.
REQ-012 SHALL pass each button through a 2-flop synchronizer and then a debouncer.
REQ-013 SHALL count, in the debouncer, consecutive cycles in which the synchronized input differs from the accepted level; the accepted level toggles when the count reaches 2^DEBOUNCE_WIDTH-1, and the count clears whenever the inputs agree or the level toggles.
REQ-014 SHALL define a press as a 0->1 transition of the debounced btn_next level; mode changes on the clock edge after the debounced level rises.
REQ-015 SHALL implement a mode FSM: CHASE(0) -> BOUNCE(1) -> COUNT(2) -> FILL(3) -> CHASE, advancing one state per press and otherwise holding.
REQ-016 SHALL, on every mode change, load the pattern register with the new mode's initial value: CHASE 8'h01, BOUNCE 8'h01 with direction left, COUNT 8'h00, FILL 8'h00.
REQ-017 SHALL, in CHASE, update the pattern on each applied tick as {p[6:0], ~|p[6:0]}; from any value it self-recovers to a single rotating one.
REQ-018 SHALL, in BOUNCE, shift the one-hot pattern one position per applied tick, reversing direction on reaching bit 7 or bit 0 (sequence 01,02,..,80,40,..,01,02,..).
REQ-019 SHALL, in COUNT, increment the pattern by 1 per applied tick, modulo 256 (8'hFF -> 8'h00).
REQ-020 SHALL, in FILL, update the pattern as the Johnson sequence {p[6:0], ~p[7]}, with period 16.
REQ-021 SHALL treat a tick as applied when tick=1, debounced hold=0, and no mode change occurs in the same cycle.
REQ-022 SHALL give a mode change priority over a simultaneous tick: the pattern reloads and that tick is discarded.
REQ-023 SHALL NOT let hold block mode changes; a press during hold still changes mode and reloads the pattern.
REQ-024 SHALL increment IO_LED[23:16] on each applied tick, wrapping at 8 bits, and clear it to 0 on a mode change.
REQ-025 SHALL increment IO_LED[15:8] on each mode change, wrapping at 8 bits.
REQ-026 SHALL register LED and IO_LED so that they reflect the new pattern and counters one cycle after the update edge, with no combinational path from the inputs.

Reset
REQ-027 SHALL, while rst=1 at a clk edge, clear the prescaler, synchronizers, debounce counters, debounced levels, and both status counters.
REQ-028 SHALL, under that same reset, set mode to CHASE, set the pattern to 8'h01 with BOUNCE direction left, and drive tick=0.
REQ-029 SHALL produce outputs after reset of LED=8'h01, IO_LED=24'h000001, mode=2'd0, tick=0.
REQ-030 SHALL let a reset asserted mid-operation override all other activity in that cycle, including a pending press or tick.

Verification (TICK_WIDTH=4, DEBOUNCE_WIDTH=2)
REQ-031 SHALL verify CHASE: reset, then 8 ticks -> LED steps 02,04,..,80,01 and IO_LED[23:16]=8.
REQ-032 SHALL verify debounce: a 2-cycle btn_next glitch -> no mode change; a held press -> mode=1, LED=01, IO_LED[15:8]=1, IO_LED[3:0]=4'b0010.
REQ-033 SHALL verify BOUNCE: 14 ticks -> LED reaches 80 then returns to 01; direction reverses at both ends.
REQ-034 SHALL verify COUNT and FILL: COUNT 256 ticks -> LED wraps to 00; FILL 16 ticks -> LED sequence 01,03,..,FF,FE,..,00.
REQ-035 SHALL verify hold: hold high across 5 ticks -> LED and IO_LED[23:16] unchanged; a press during hold -> mode advances and the pattern reloads.
REQ-036 SHALL verify priority: a press aligned with a tick -> pattern equals the new mode's initial value and the tick count is 0; rst pulsed mid-FILL -> outputs equal the REQ-029 values.
